// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Stage vectors are indexed with IF_ID..MA_WB.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        TRAP_FLUSH = 2'd1,
        FENCE_WAIT = 2'd2
    } ctl_state_t;

    localparam int IF_ID = 0;
    localparam int ID_EX = 1;
    localparam int EX_MA = 2;
    localparam int MA_WB = 3;

    localparam int PIPE_REG_W = 5;

    typedef logic [3:0] stage_vec_t;

    localparam stage_vec_t STAGES_NONE = 4'b0000;
    localparam stage_vec_t STAGES_ALL  = 4'b1111;

    // Build a stage vector from one flag per stage register.
    function automatic stage_vec_t stage_mask(
        input logic if_id,
        input logic id_ex,
        input logic ex_ma,
        input logic ma_wb
    );
        stage_vec_t m;
        m        = STAGES_NONE;
        m[IF_ID] = if_id;
        m[ID_EX] = id_ex;
        m[EX_MA] = ex_ma;
        m[MA_WB] = ma_wb;
        return m;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctl_load_use_detect.sv
// Load-use hazard compare: the instruction in ID reads the register that a
// load in EX has not yet produced. x0 never creates a hazard.
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_en,
    input  logic             id_rs2_en,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_load,
    output logic             hazard
);

    logic rd_nonzero_s;
    logic rs1_hit_s;
    logic rs2_hit_s;

    assign rd_nonzero_s = (ex_rd != {REG_W{1'b0}});
    assign rs1_hit_s    = id_rs1_en & (id_rs1 == ex_rd);
    assign rs2_hit_s    = id_rs2_en & (id_rs2 == ex_rd);
    assign hazard       = ex_load & rd_nonzero_s & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Central stall/flush sequencer for the if_id, id_ex, ex_ma and ma_wb stage
// registers. Resolves one hazard event per cycle by priority, and runs a
// small FSM for the multi-cycle trap flush and the fence.i drain.
// Optional performance counters are built when PIPE_HAZARD_PERF_EN is defined;
// otherwise stall_cnt/flush_cnt are tied to zero.
module pipe_hazard_ctl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int REG_W        = PIPE_REG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_en,
    input  logic             id_rs2_en,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_load,
    input  logic             ex_busy,
    input  logic             ma_busy,
    input  logic             if_busy,
    input  logic             bj_en,
    input  logic             trap_en,
    input  logic             id_fence_i,
    input  logic             sb_empty,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_ma,
    output logic             stall_ma_wb,
    output logic             clear_if_id,
    output logic             clear_id_ex,
    output logic             clear_ex_ma,
    output logic             clear_ma_wb,
    output logic             refetch,
    output logic [1:0]       ctl_state,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
);

    // Counter holds the flush cycles still to go after the current one.
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    // A single-cycle flush is fully handled in the trap cycle itself.
    localparam ctl_state_t TRAP_NEXT = (FLUSH_CYCLES > 1) ? TRAP_FLUSH : RUN;
    localparam logic [CNT_W-1:0] TRAP_CNT = (FLUSH_CYCLES > 1) ? CNT_RELOAD : CNT_ZERO;

    ctl_state_t       state_r;
    ctl_state_t       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    stage_vec_t       stall_s;
    stage_vec_t       clear_s;
    logic             stall_pc_s;
    logic             refetch_s;
    logic             load_use_s;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use (
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .id_rs1_en (id_rs1_en),
        .id_rs2_en (id_rs2_en),
        .ex_rd     (ex_rd),
        .ex_load   (ex_load),
        .hazard    (load_use_s)
    );

    // FSM state and flush counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state and per-stage stall/clear decode, one event per cycle by priority.
    always_comb begin
        stall_s    = STAGES_NONE;
        clear_s    = STAGES_NONE;
        stall_pc_s = 1'b0;
        refetch_s  = 1'b0;
        state_s    = state_r;
        cnt_s      = cnt_r;
        if (!rst_n) begin
            // Bubbles everywhere while the core is held in reset.
            clear_s = STAGES_ALL;
            state_s = RUN;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                RUN: begin
                    if (trap_en) begin
                        clear_s = STAGES_ALL;
                        state_s = TRAP_NEXT;
                        cnt_s   = TRAP_CNT;
                    end else if (ma_busy) begin
                        stall_pc_s = 1'b1;
                        stall_s    = stage_mask(1'b1, 1'b1, 1'b1, 1'b0);
                        clear_s    = stage_mask(1'b0, 1'b0, 1'b0, 1'b1);
                    end else if (ex_busy) begin
                        stall_pc_s = 1'b1;
                        stall_s    = stage_mask(1'b1, 1'b1, 1'b0, 1'b0);
                        clear_s    = stage_mask(1'b0, 1'b0, 1'b1, 1'b0);
                    end else if (bj_en) begin
                        // Redirect proceeds: PC loads the branch target.
                        clear_s = stage_mask(1'b1, 1'b1, 1'b0, 1'b0);
                    end else if (load_use_s) begin
                        stall_pc_s = 1'b1;
                        stall_s    = stage_mask(1'b1, 1'b0, 1'b0, 1'b0);
                        clear_s    = stage_mask(1'b0, 1'b1, 1'b0, 1'b0);
                    end else if (id_fence_i) begin
                        // fence.i moves on to EX; nothing new is fetched behind it.
                        stall_pc_s = 1'b1;
                        clear_s    = stage_mask(1'b1, 1'b0, 1'b0, 1'b0);
                        state_s    = FENCE_WAIT;
                    end else if (if_busy) begin
                        clear_s = stage_mask(1'b1, 1'b0, 1'b0, 1'b0);
                    end else begin
                        state_s = RUN;
                    end
                end
                TRAP_FLUSH: begin
                    clear_s = STAGES_ALL;
                    if (trap_en) begin
                        cnt_s = CNT_RELOAD;
                    end else if (cnt_r <= CNT_ONE) begin
                        state_s = RUN;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                FENCE_WAIT: begin
                    stall_pc_s = 1'b1;
                    if (trap_en) begin
                        // Trap abandons the drain; the handler fetch replaces refetch.
                        clear_s = STAGES_ALL;
                        state_s = TRAP_NEXT;
                        cnt_s   = TRAP_CNT;
                    end else begin
                        // if_id only ever holds a bubble here, so it is cleared, not held.
                        clear_s[IF_ID] = 1'b1;
                        if (ma_busy) begin
                            stall_s[ID_EX] = 1'b1;
                            stall_s[EX_MA] = 1'b1;
                            clear_s[MA_WB] = 1'b1;
                        end else if (ex_busy) begin
                            stall_s[ID_EX] = 1'b1;
                            clear_s[EX_MA] = 1'b1;
                        end else if (bj_en) begin
                            clear_s[ID_EX] = 1'b1;
                        end else begin
                            clear_s[ID_EX] = 1'b0;
                        end
                        if (sb_empty && !ma_busy) begin
                            refetch_s = 1'b1;
                            state_s   = RUN;
                        end else begin
                            state_s = FENCE_WAIT;
                        end
                    end
                end
                default: begin
                    clear_s = STAGES_ALL;
                    state_s = RUN;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    assign stall_pc    = stall_pc_s;
    assign stall_if_id = stall_s[IF_ID];
    assign stall_id_ex = stall_s[ID_EX];
    assign stall_ex_ma = stall_s[EX_MA];
    assign stall_ma_wb = stall_s[MA_WB];
    assign clear_if_id = clear_s[IF_ID];
    assign clear_id_ex = clear_s[ID_EX];
    assign clear_ex_ma = clear_s[EX_MA];
    assign clear_ma_wb = clear_s[MA_WB];
    assign refetch     = refetch_s;
    assign ctl_state   = state_r;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;
    logic        flush_evt_s;

    // A flush starts on any accepted trap, or on a branch redirect not masked by a stall.
    assign flush_evt_s = trap_en |
                         ((state_r != TRAP_FLUSH) & bj_en & ~ma_busy & ~ex_busy);

    // Free-running performance counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            stall_cnt_r <= stall_cnt_r + {31'd0, stall_pc_s};
            flush_cnt_r <= flush_cnt_r + {31'd0, flush_evt_s};
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Self-checking bench for pipe_hazard_ctl (FLUSH_CYCLES=2). Expected output
// vectors are queued as each cycle's stimulus is applied and compared when
// the cycle's outputs are sampled on the falling edge.
module tb_pipe_hazard_ctl;

    localparam int REG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
    logic             id_rs1_en, id_rs2_en, ex_load, ex_busy, ma_busy, if_busy;
    logic             bj_en, trap_en, id_fence_i, sb_empty;
    logic             stall_pc, stall_if_id, stall_id_ex, stall_ex_ma, stall_ma_wb;
    logic             clear_if_id, clear_id_ex, clear_ex_ma, clear_ma_wb, refetch;
    logic [1:0]       ctl_state;
    logic [31:0]      stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;
    int unsigned stall_tally = 0;
    int unsigned flush_tally = 0;
    logic [11:0] exp_q[$];

    pipe_hazard_ctl #(.FLUSH_CYCLES(2), .REG_W(REG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
        .ex_rd(ex_rd), .ex_load(ex_load), .ex_busy(ex_busy), .ma_busy(ma_busy),
        .if_busy(if_busy), .bj_en(bj_en), .trap_en(trap_en), .id_fence_i(id_fence_i),
        .sb_empty(sb_empty),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .stall_ex_ma(stall_ex_ma), .stall_ma_wb(stall_ma_wb),
        .clear_if_id(clear_if_id), .clear_id_ex(clear_id_ex), .clear_ex_ma(clear_ex_ma),
        .clear_ma_wb(clear_ma_wb), .refetch(refetch), .ctl_state(ctl_state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Vector layout: {stall_pc, stall[if_id,id_ex,ex_ma,ma_wb], clear[same order], refetch, state}
    function automatic logic [11:0] ev(input logic pc, input logic [3:0] st,
                                       input logic [3:0] cl, input logic rf,
                                       input logic [1:0] s);
        return {pc, st, cl, rf, s};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {stall_pc, stall_if_id, stall_id_ex, stall_ex_ma, stall_ma_wb,
                clear_if_id, clear_id_ex, clear_ex_ma, clear_ma_wb, refetch, ctl_state};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_rs1_en = 1'b0; id_rs2_en = 1'b0; ex_load = 1'b0; ex_busy = 1'b0;
        ma_busy = 1'b0; if_busy = 1'b0; bj_en = 1'b0; trap_en = 1'b0;
        id_fence_i = 1'b0; sb_empty = 1'b0;
    endtask

    // One cycle: inputs already applied; queue expectation, compare mid-cycle, advance.
    task automatic step(input string tag, input logic [11:0] e, input logic fl);
        logic [11:0] popped;
        exp_q.push_back(e);
        @(negedge clk);
        popped = exp_q.pop_front();
        check_eq(tag, {20'd0, obs_vec()}, {20'd0, popped});
        if (popped[11]) stall_tally++;
        if (fl) flush_tally++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_perf(input string tag);
`ifdef PIPE_HAZARD_PERF_EN
        check_eq({tag, "_stall_cnt"}, stall_cnt, stall_tally);
        check_eq({tag, "_flush_cnt"}, flush_cnt, flush_tally);
`else
        check_eq({tag, "_stall_cnt"}, stall_cnt, 32'd0);
        check_eq({tag, "_flush_cnt"}, flush_cnt, 32'd0);
`endif
    endtask

    logic [11:0] e_idle, e_reset, e_lu, e_trap_run, e_tf, e_ma, e_exb, e_bj, e_ifb;
    logic [11:0] e_fence_run, e_fw, e_fw_ma, e_fw_exit, e_fw_trap;

    initial begin
        e_idle      = ev(1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0);
        e_reset     = ev(1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0);
        e_lu        = ev(1'b1, 4'b1000, 4'b0100, 1'b0, 2'd0);
        e_trap_run  = ev(1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0);
        e_tf        = ev(1'b0, 4'b0000, 4'b1111, 1'b0, 2'd1);
        e_ma        = ev(1'b1, 4'b1110, 4'b0001, 1'b0, 2'd0);
        e_exb       = ev(1'b1, 4'b1100, 4'b0010, 1'b0, 2'd0);
        e_bj        = ev(1'b0, 4'b0000, 4'b1100, 1'b0, 2'd0);
        e_ifb       = ev(1'b0, 4'b0000, 4'b1000, 1'b0, 2'd0);
        e_fence_run = ev(1'b1, 4'b0000, 4'b1000, 1'b0, 2'd0);
        e_fw        = ev(1'b1, 4'b0000, 4'b1000, 1'b0, 2'd2);
        e_fw_ma     = ev(1'b1, 4'b0110, 4'b1001, 1'b0, 2'd2);
        e_fw_exit   = ev(1'b1, 4'b0000, 4'b1000, 1'b1, 2'd2);
        e_fw_trap   = ev(1'b1, 4'b0000, 4'b1111, 1'b0, 2'd2);

        idle_in();
        rst_n = 1'b0;
        #3;
        check_eq("reset_vec", {20'd0, obs_vec()}, {20'd0, e_reset});
        check_perf("reset");
        #3 rst_n = 1'b1;

        step("idle", e_idle, 1'b0);

        // Load-use on rs1: exactly one bubble, then the load has moved on.
        ex_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_en = 1'b1;
        step("lu_rs1", e_lu, 1'b0);
        ex_load = 1'b0;
        step("lu_rs1_after", e_idle, 1'b0);
        // rs2 match counts; rs1 match with enable low does not.
        ex_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_en = 1'b0;
        id_rs2 = 5'd7; id_rs2_en = 1'b1;
        step("lu_rs2", e_lu, 1'b0);
        id_rs2_en = 1'b0;
        step("lu_rs1_dis", e_idle, 1'b0);
        // x0 never hazards.
        ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_en = 1'b1;
        step("lu_x0", e_idle, 1'b0);
        idle_in();

        // Trap pulse: two clear cycles, state 0 -> 1 -> 0.
        trap_en = 1'b1;
        step("trap_run", e_trap_run, 1'b1);
        trap_en = 1'b0;
        step("trap_flush", e_tf, 1'b0);
        step("trap_done", e_idle, 1'b0);
        // Re-trap during the flush extends it.
        trap_en = 1'b1;
        step("trap2_run", e_trap_run, 1'b1);
        step("trap2_reload", e_tf, 1'b1);
        trap_en = 1'b0;
        step("trap2_flush", e_tf, 1'b0);
        step("trap2_done", e_idle, 1'b0);

        // Memory wait masks a pending branch for 3 cycles.
        ma_busy = 1'b1; bj_en = 1'b1;
        for (int i = 0; i < 3; i++) step("ma_busy_bj", e_ma, 1'b0);
        ma_busy = 1'b0;
        step("bj_after_ma", e_bj, 1'b1);
        bj_en = 1'b0;
        step("bj_done", e_idle, 1'b0);

        // Multicycle EX masks a load-use that resolves afterwards.
        ex_busy = 1'b1; ex_load = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_rs2_en = 1'b1;
        step("ex_busy", e_exb, 1'b0);
        ex_busy = 1'b0;
        step("lu_after_ex", e_lu, 1'b0);
        idle_in();
        if_busy = 1'b1;
        step("if_busy", e_ifb, 1'b0);
        if_busy = 1'b0;

        // fence.i drain: 4 waits, one blocked by ma_busy, then refetch.
        id_fence_i = 1'b1;
        step("fence_run", e_fence_run, 1'b0);
        id_fence_i = 1'b0;
        for (int i = 0; i < 4; i++) step("fence_wait", e_fw, 1'b0);
        ma_busy = 1'b1; sb_empty = 1'b1;
        step("fence_wait_ma", e_fw_ma, 1'b0);
        ma_busy = 1'b0;
        step("fence_refetch", e_fw_exit, 1'b0);
        sb_empty = 1'b0;
        step("fence_done", e_idle, 1'b0);
        check_perf("mid");

        // Trap during the drain: no refetch.
        id_fence_i = 1'b1;
        step("fence2_run", e_fence_run, 1'b0);
        id_fence_i = 1'b0;
        step("fence2_wait", e_fw, 1'b0);
        trap_en = 1'b1; sb_empty = 1'b1;
        step("fence2_trap", e_fw_trap, 1'b1);
        trap_en = 1'b0;
        step("fence2_flush", e_tf, 1'b0);
        sb_empty = 1'b0;
        step("fence2_done", e_idle, 1'b0);

        // Reset asserted in the middle of a drain.
        id_fence_i = 1'b1;
        step("fence3_run", e_fence_run, 1'b0);
        id_fence_i = 1'b0;
        step("fence3_wait", e_fw, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("reset_mid", {20'd0, obs_vec()}, {20'd0, e_reset});
        stall_tally = 0;
        flush_tally = 0;
        check_perf("reset_mid");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        if_busy = 1'b1;
        step("if_busy_after_rst", e_ifb, 1'b0);
        if_busy = 1'b0;
        step("final_idle", e_idle, 1'b0);
        check_perf("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
